// File: rtl/gray_seq_pkg.sv
// Shared types and constants for the Gray-code sequencer.
// The default width, the run/idle state type and the helper for a full-cycle run length.
package gray_seq_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A programmed step count of zero means a full cycle of 2^width words.
  function automatic int unsigned full_run(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/gray_seq_if.sv
// Request/response stream bundle between the sequence requester and the Gray sequencer.
// The requester uses the master modport and the sequencer uses the slave modport.
interface gray_seq_if
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             dir;
  logic [WIDTH-1:0] steps;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             out_ready;
  logic [WIDTH-1:0] gray;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start,
    output dir,
    output steps,
    output load,
    output load_val,
    output out_ready,
    input  gray,
    input  out_valid,
    input  busy,
    input  done,
    input  wrap
  );

  modport slave (
    input  start,
    input  dir,
    input  steps,
    input  load,
    input  load_val,
    input  out_ready,
    output gray,
    output out_valid,
    output busy,
    output done,
    output wrap
  );

endinterface

// File: rtl/gray_seq_ctrl_enc.sv
// Parameterised combinational binary-to-Gray encoder.
// Bit i of the result is b[i] ^ b[i+1], and the MSB passes straight through.
module gray_enc
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Shifting in a zero leaves the MSB unchanged and XORs each lower bit with its upper neighbour.
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray-code run sequencer. It holds the binary count, the step budget and the IDLE/RUN state,
// and streams gray(count) on a valid/ready output. WIDTH must be at least 2.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  gray_seq_if.slave   bus
);

  localparam logic [0:0]     ST_IDLE   = IDLE;
  localparam logic [0:0]     ST_RUN    = RUN;
  localparam logic [WIDTH:0] FULL_RUN  = (WIDTH + 1)'(full_run(WIDTH));
  localparam logic [WIDTH:0] LAST_STEP = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH:0]   remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             xfer;

  assign xfer = (state_q == ST_RUN) && bus.out_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path infers a latch.
    state_d     = state_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A load sets the count before the start, so a run begins from load_val.
        if (bus.load) begin
          count_d = bus.load_val;
        end
        if (bus.start) begin
          dir_d       = bus.dir;
          remaining_d = (bus.steps == '0) ? FULL_RUN : {1'b0, bus.steps};
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (xfer) begin
          count_d     = dir_q ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
          remaining_d = remaining_q - LAST_STEP;
          wrap_d      = dir_q ? (count_q == MAX_COUNT) : (count_q == '0);
          if (remaining_q == LAST_STEP) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The encoder sits on the next count, so gray is a register output that follows count_q exactly.
  gray_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .bin  (count_d),
    .gray (gray_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      gray_q      <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      gray_q      <= gray_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.gray      = gray_q;
  assign bus.out_valid = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl. Each step compares {valid, busy, done, wrap, gray}
// against hand-computed values.
module tb_gray_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  gray_seq_if #(.WIDTH(3)) bus ();

  gray_seq_ctrl #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_st(input logic v, input logic d, input logic w,
                                        input logic [2:0] g);
    return {v, v, d, w, g};
  endfunction

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {bus.out_valid, bus.busy, bus.done, bus.wrap, bus.gray};
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed vbdw_gray=%b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] up_seq [8];

  initial begin
    up_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    checks        = 0;
    passed        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.dir       = 1'b0;
    bus.steps     = 3'd0;
    bus.load      = 1'b0;
    bus.load_val  = 3'd0;
    bus.out_ready = 1'b0;

    #3;
    check("reset", exp_st(1'b0, 1'b0, 1'b0, 3'b000));
    #4 rst_n = 1'b1;
    tick();
    check("idle_after_reset", exp_st(1'b0, 1'b0, 1'b0, 3'b000));

    // Full up-count run, steps=0 means 8 words.
    bus.start = 1'b1; bus.dir = 1'b1; bus.steps = 3'd0; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("up_word0", exp_st(1'b1, 1'b0, 1'b0, up_seq[0]));
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("up_word%0d", i), exp_st(1'b1, 1'b0, 1'b0, up_seq[i]));
    end
    tick();
    check("up_done_wrap", exp_st(1'b0, 1'b1, 1'b1, 3'b000));

    // Load 5, count down 3 words.
    bus.load = 1'b1; bus.load_val = 3'd5;
    tick();
    bus.load = 1'b0;
    check("load5_idle", exp_st(1'b0, 1'b0, 1'b0, 3'b111));
    bus.start = 1'b1; bus.dir = 1'b0; bus.steps = 3'd3;
    tick();
    bus.start = 1'b0;
    check("dn_word0", exp_st(1'b1, 1'b0, 1'b0, 3'b111));
    tick();
    check("dn_word1", exp_st(1'b1, 1'b0, 1'b0, 3'b110));
    tick();
    check("dn_word2", exp_st(1'b1, 1'b0, 1'b0, 3'b010));
    tick();
    check("dn_done", exp_st(1'b0, 1'b1, 1'b0, 3'b011));

    // From 7 count up 2 words, with ready toggling 1,0,0,1.
    bus.load = 1'b1; bus.load_val = 3'd7;
    tick();
    bus.load = 1'b0;
    check("load7_idle", exp_st(1'b0, 1'b0, 1'b0, 3'b100));
    bus.start = 1'b1; bus.dir = 1'b1; bus.steps = 3'd2; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("bp_word0", exp_st(1'b1, 1'b0, 1'b0, 3'b100));
    tick();
    check("bp_wrap", exp_st(1'b1, 1'b0, 1'b1, 3'b000));
    bus.out_ready = 1'b0;
    tick();
    check("bp_stall1", exp_st(1'b1, 1'b0, 1'b0, 3'b000));
    tick();
    check("bp_stall2", exp_st(1'b1, 1'b0, 1'b0, 3'b000));
    bus.out_ready = 1'b1;
    tick();
    check("bp_done", exp_st(1'b0, 1'b1, 1'b0, 3'b001));

    // Load 3 and start in the same cycle, one step.
    bus.load = 1'b1; bus.load_val = 3'd3; bus.start = 1'b1; bus.dir = 1'b1; bus.steps = 3'd1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    check("ls_word0", exp_st(1'b1, 1'b0, 1'b0, 3'b010));
    tick();
    check("ls_done", exp_st(1'b0, 1'b1, 1'b0, 3'b110));

    // start/load pulsed during a 3-word run from 4 must be ignored.
    bus.start = 1'b1; bus.dir = 1'b1; bus.steps = 3'd3;
    tick();
    check("ign_word0", exp_st(1'b1, 1'b0, 1'b0, 3'b110));
    bus.start = 1'b1; bus.load = 1'b1; bus.load_val = 3'd0; bus.steps = 3'd1; bus.dir = 1'b0;
    tick();
    bus.start = 1'b0; bus.load = 1'b0;
    check("ign_word1", exp_st(1'b1, 1'b0, 1'b0, 3'b111));
    tick();
    check("ign_word2", exp_st(1'b1, 1'b0, 1'b0, 3'b101));
    // Start in the done cycle to check the one-cycle gap between runs.
    bus.start = 1'b1; bus.dir = 1'b1; bus.steps = 3'd0;
    tick();
    check("ign_done", exp_st(1'b0, 1'b1, 1'b0, 3'b100));
    tick();
    bus.start = 1'b0;
    check("b2b_word0", exp_st(1'b1, 1'b0, 1'b0, 3'b100));
    tick();
    check("b2b_word1_wrap", exp_st(1'b1, 1'b0, 1'b1, 3'b000));
    tick();
    check("b2b_word2", exp_st(1'b1, 1'b0, 1'b0, 3'b001));
    tick();
    check("b2b_word3", exp_st(1'b1, 1'b0, 1'b0, 3'b011));

    // Asynchronous reset mid-run after three accepted words.
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset", exp_st(1'b0, 1'b0, 1'b0, 3'b000));
    #10 rst_n = 1'b1;
    tick();
    check("post_reset1", exp_st(1'b0, 1'b0, 1'b0, 3'b000));
    tick();
    check("post_reset2", exp_st(1'b0, 1'b0, 1'b0, 3'b000));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gray_seq_ctrl.md
# gray_seq_ctrl

Sequencer that drives the 3-bit binary-to-Gray encoder through a programmed run of count steps, up or down, and presents each Gray word on a valid/ready output stream. It owns the binary count register, the step budget and the run/idle state machine. It sits between the control logic that requests Gray sequences (position and encoder-emulation paths) and the downstream consumer of Gray words.

## Interface
- `WIDTH`, default 3: count and Gray word width; must be ≥ 2.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous reset, active-low.
- `start` input, 1 bit: begin a run. Sampled only in IDLE.
- `dir` input, 1 bit: 1 = count up, 0 = count down. Latched at start.
- `steps` input, WIDTH bits: words to emit. 0 means 2^WIDTH. Latched at start.
- `load` input, 1 bit: overwrite the binary count with `load_val`. Honoured only in IDLE.
- `load_val` input, WIDTH bits: value for `load`.
- `out_ready` input, 1 bit: consumer accepts `gray` this cycle.
- `gray` output, WIDTH bits: registered Gray word, equal to gray(count).
- `out_valid` output, 1 bit: `gray` is valid.
- `busy` output, 1 bit: high in RUN.
- `done` output, 1 bit: one-cycle pulse when the last word of a run is accepted.
- `wrap` output, 1 bit: one-cycle pulse when an accepted transfer wraps the count (max→0 up, 0→max down).

## Operation
- States: IDLE and RUN.
- IDLE behaviour:
  - `out_valid` = 0.
  - `load` sets count = `load_val` and `gray` = gray(`load_val`).
  - `start` latches `dir` and `steps` (0 → 2^WIDTH) into `remaining`, then goes to RUN.
  - `load` and `start` in the same cycle: the load applies and the run begins from `load_val`.
- RUN behaviour:
  - `out_valid` = 1, `busy` = 1.
  - On a transfer (`out_valid` && `out_ready`): count steps ±1 modulo 2^WIDTH, `gray` updates to gray(new count), and `remaining` decrements.
  - If `remaining` was 1 on that transfer: `done` pulses, the state returns to IDLE, and the count keeps the post-step value.
  - `start`, `load`, `dir` and `steps` are ignored in RUN.
- Encoding: g[MSB] = b[MSB]; g[i] = b[i] XOR b[i+1] for i < MSB. Adjacent emitted words differ in exactly one bit, including across a wrap.
- `remaining` is WIDTH+1 bits wide so that it can hold 2^WIDTH.

## Timing
- Reset values: count = 0, `gray` = 0, `remaining` = 0, state IDLE, and `out_valid`, `busy`, `done`, `wrap` all 0.
- A start sampled at edge T gives `out_valid` = 1 from T, with `gray` = gray(start count). First-word latency is one cycle.
- Back-pressure: while `out_valid` && !`out_ready`, `gray` holds stable and no state changes.
- Throughput: one word per cycle with `out_ready` held high.
- `done` and `wrap` are registered. They are high in the cycle after the transfer that caused them, and can both be high together.
- `busy` drops on the same edge that asserts `done`. A new `start` is accepted on that cycle, so consecutive runs have a one-cycle gap.
- Reset asserted mid-run immediately forces all reset values. The partial run is discarded, with no `done`.

## Structure
- Package `gray_seq_pkg`:
  - `state_t` enum {IDLE, RUN}.
  - Default `WIDTH` constant.
  - Function or constant for 2^WIDTH.
- Sub-module `gray_enc`: parameterised combinational binary-to-Gray encoder, instantiated once on the next-count value so that `gray` is a register output.

## Test plan
- Reset, then start with `dir`=1, `steps`=0, `out_ready`=1 → `gray` = 000, 001, 011, 010, 110, 111, 101, 100 on consecutive cycles. `wrap` and `done` pulse one cycle after word 100 is accepted; count = 0.
- Load 5, start with `dir`=0, `steps`=3, `out_ready`=1 → `gray` = 111, 110, 010; `done` pulses; count ends at 2.
- Start with `dir`=1, `steps`=2 from count 7, `out_ready` toggling 1,0,0,1 → words 100 then 000. 000 holds through both stall cycles; `wrap` pulses after the first transfer.
- `load`=1 with `load_val`=3 and `start`=1 in the same IDLE cycle, `steps`=1 → a single word 010, then `done`. Count = 4, so `gray` = 110 in IDLE.
- `start`/`load` pulsed in RUN → no effect on the sequence or `remaining`.
- `rst_n` low mid-run after 3 words → all outputs 0 immediately, no `done`. After release, IDLE with `gray` = 000.
